// File: rtl/tdm_demux.sv
// Purpose : TDM word-bus receiver; routes slot k of each sof-tagged frame to channel k.
// Latency : last word sampled on edge N -> ch_data/frame_valid visible in cycle N+1.
// Backpressure: none; the receiver always accepts, and in_valid=0 simply stalls a frame.
//
// Ports:
//   clk, rst_n   rising-edge clock; asynchronous active-low reset
//   in_data      WIDTH-bit TDM word, sampled when in_valid=1
//   in_valid     qualifies in_data/in_sof
//   in_sof       marks the word as slot 0 of a frame
//   ch_data      CHANNELS*WIDTH; channel k = ch_data[k*WIDTH +: WIDTH]
//   frame_valid  1-cycle pulse when ch_data has just been updated
//   sync         1 while locked to the frame structure (RUN)
//   err          1-cycle pulse on a framing error
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic                      frame_valid,
    output logic                      sync,
    output logic                      err
);

    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [SW-1:0]    slot;
    // The last slot is never stored: it goes straight into ch_data with the
    // shadow words, so only CHANNELS-1 shadow entries are needed.
    logic [WIDTH-1:0] shadow [CHANNELS-1];

    logic [CHANNELS*WIDTH-1:0] frame_word;

    always_comb begin
        frame_word = '0;
        for (int k = 0; k < CHANNELS - 1; k++) begin
            frame_word[k*WIDTH +: WIDTH] = shadow[k];
        end
        frame_word[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
    end

    assign sync = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            for (int k = 0; k < CHANNELS - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (in_valid) begin
                if (state == HUNT) begin
                    // Words without sof are silently discarded while hunting.
                    if (in_sof) begin
                        shadow[0] <= in_data;
                        slot      <= SW'(1);
                        state     <= RUN;
                    end
                end else if (in_sof) begin
                    // sof in the middle of a frame: drop the partial frame
                    // and resynchronise on this word.
                    if (slot != '0) begin
                        err <= 1'b1;
                    end
                    shadow[0] <= in_data;
                    slot      <= SW'(1);
                end else if (slot == '0) begin
                    // Expected sof did not arrive: lose lock.
                    err   <= 1'b1;
                    state <= HUNT;
                end else if (slot == LAST) begin
                    ch_data     <= frame_word;
                    frame_valid <= 1'b1;
                    slot        <= '0;
                end else begin
                    for (int k = 1; k < CHANNELS - 1; k++) begin
                        if (slot == SW'(k)) begin
                            shadow[k] <= in_data;
                        end
                    end
                    slot <= slot + SW'(1);
                end
            end
        end
    end

endmodule
